aes192_key_schedule_ctrl: RTL and testbench
===========================================

Name: aes192_key_schedule_ctrl

Overview:
Sequencer for the AES-192 key-expansion step datapath. The step datapath computes one 6-word expansion from the previous 6 words and a round constant; its SubWord stage is registered. This block loads a 192-bit cipher key and drives the step datapath through 8 expansion steps with the correct Rcon. It stores the 13 round keys (52 words) and serves them to the AES-192 decryption round logic in decryption order (round 12 first).

Parameters:
SBOX_LAT, 1, clock cycles from step-datapath input change to a valid NEW_KEY; legal range 1..3.
NUM_ROUNDS, 12, AES-192 round count; fixed, stored round keys = NUM_ROUNDS+1.

Ports:
CLK  input  1  system clock, rising edge.
RESET_N  input  1  asynchronous active-low reset.
START  input  1  single-cycle request to expand KEY_IN; sampled only in IDLE or DONE.
KEY_IN  input  192  cipher key, bit 0 = MSB; sampled on the edge START is accepted.
BUSY  output  1  high while expansion is in progress.
KEYS_VALID  output  1  high while all 13 round keys are stored and readable.
STEP_PREV_KEY  output  192  to step-datapath PREVIOUS_KEY (working 6-word register).
STEP_RCON  output  32  to step-datapath Round_Constant; {rcon_byte, 24'h0}.
STEP_NEW_KEY  input  192  from step-datapath NEW_KEY.
RK_ADDR  input  4  decryption-order round-key index; 0 selects round key 12, 12 selects round key 0.
RK_DATA  output  128  registered round key for RK_ADDR.

Behaviour:
- Clock CLK; reset RESET_N asynchronous, active-low; both fixed. Reset asserted at any time, including mid-expansion, immediately forces: state IDLE, BUSY=0, KEYS_VALID=0, RK_DATA=0, STEP_PREV_KEY=0, STEP_RCON=0, step counter=0, wait counter=0, all 52 storage words=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + START: at that edge, latch KEY_IN into the working register and into storage words 0..5. Clear the step and wait counters, KEYS_VALID<=0, BUSY<=1, go to RUN.
- RUN:
  - STEP_PREV_KEY = working register. STEP_RCON = rcon[step], with rcon = 01,02,04,08,10,20,40,80.
  - Wait counter increments each cycle. At the edge where it equals SBOX_LAT: capture STEP_NEW_KEY into the working register and write it to storage words 6*(step+1)..6*(step+1)+5. Words at index >51 are discarded; step 7 keeps only words 48..51. Then step++ and the wait counter clears.
  - The capture of step 7 moves the block to DONE: BUSY<=0, KEYS_VALID<=1.
- Latency: each step takes SBOX_LAT+1 cycles. KEYS_VALID is first high 8*(SBOX_LAT+1) cycles after the START edge (16 with default).
- START during RUN is ignored and has no effect on the expansion in progress.
- START in DONE restarts; KEYS_VALID drops on the accept edge.
- In IDLE and DONE, STEP_PREV_KEY holds its last value and STEP_RCON = 0.
- Read port: RK_DATA <= words 4r..4r+3, where r = 12 - RK_ADDR, registered with 1-cycle latency.
  - The read is valid in any state; contents are meaningful only while KEYS_VALID=1.
  - RK_ADDR 13..15 returns 128'h0.
  - A read of an address being written in the same cycle returns the old contents.
- All counters are sized exactly: step 3 bits, wait 2 bits. No wrap-around is reachable.

Optional Feature:
AES192_KS_ZEROIZE_EN. When defined: adds input ZEROIZE (1 bit, synchronous, highest priority over START). On an edge with ZEROIZE=1 the block clears all storage words, the working register, STEP_PREV_KEY and RK_DATA. It also sets KEYS_VALID=0 and BUSY=0 and returns to IDLE, aborting any RUN. When not defined: the port is absent and key material persists until reset or overwrite.

Test Plan:
- Reset, then KEY_IN=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b with START -> BUSY high 16 cycles; KEYS_VALID rises 16 cycles after the START edge; STEP_RCON sequence 01000000..80000000 observed one value per 2 cycles.
- After the case above: RK_ADDR=0 -> RK_DATA=e98ba06f448c773c8ecc720401002202 next cycle. RK_ADDR=11 -> 62f8ead2522c6b7bfe0c91f72402f5a5. RK_ADDR=12 -> 8e73b0f7da0e6452c810f32b809079e5. RK_ADDR=14 -> 0.
- START pulsed again at cycle 5 of RUN with a different key -> ignored; final round keys match the first key.
- RESET_N low at cycle 9 of RUN -> outputs zero asynchronously. New START after release -> full correct expansion in 16 cycles.
- SBOX_LAT=3 build -> KEYS_VALID after 32 cycles, same round keys.
- With AES192_KS_ZEROIZE_EN: ZEROIZE in DONE -> KEYS_VALID=0, RK_DATA=0 for every RK_ADDR. ZEROIZE and START on the same edge -> stays IDLE.

Source files
------------

// File: rtl/aes192_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// aes192_key_schedule_ctrl
//
// Sequencer for an external AES-192 key-expansion step datapath. The block
// loads a 192-bit cipher key and runs the step datapath through 8 expansion
// steps, each with its own round constant. It stores the 13 round keys
// (52 words) and serves them to decryption round logic, last round key first.
//
// Word numbering: word 0 of any 192/128-bit bus is its most-significant
// 32 bits, so AES byte 0 sits in the top byte of the vector.
//
// Ports
//   CLK            system clock, rising edge
//   RESET_N        asynchronous active-low reset
//   START          single-cycle expand request, accepted in IDLE or DONE
//   ZEROIZE        (only with AES192_KS_ZEROIZE_EN) synchronous wipe of all
//                  key material; takes priority over START
//   KEY_IN         cipher key, sampled on the accept edge
//   BUSY           expansion in progress
//   KEYS_VALID     all 13 round keys stored and readable
//   STEP_PREV_KEY  working 6-word register, to step-datapath PREVIOUS_KEY
//   STEP_RCON      {rcon_byte, 24'h0} while running, zero otherwise
//   STEP_NEW_KEY   6-word result from the step datapath
//   RK_ADDR        decryption-order index: 0 -> round key 12, 12 -> round key 0
//   RK_DATA        registered round key for RK_ADDR (zero for 13..15)
//
// Parameters
//   SBOX_LAT       cycles from step-datapath input change to valid NEW_KEY (1..3)
//   NUM_ROUNDS     AES-192 round count, fixed at 12
//
// Build option
//   AES192_KS_ZEROIZE_EN  adds the ZEROIZE input.
// -----------------------------------------------------------------------------
module aes192_key_schedule_ctrl #(
    parameter int SBOX_LAT   = 1,
    parameter int NUM_ROUNDS = 12
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
`ifdef AES192_KS_ZEROIZE_EN
    input  logic         ZEROIZE,
`endif
    input  logic [191:0] KEY_IN,
    output logic         BUSY,
    output logic         KEYS_VALID,
    output logic [191:0] STEP_PREV_KEY,
    output logic [31:0]  STEP_RCON,
    input  logic [191:0] STEP_NEW_KEY,
    input  logic [3:0]   RK_ADDR,
    output logic [127:0] RK_DATA
);

    localparam int         NUM_WORDS = 4 * (NUM_ROUNDS + 1);
    localparam logic [1:0] LAT       = 2'(SBOX_LAT);
    localparam logic [2:0] LAST_STEP = 3'd7;
    localparam logic [3:0] LAST_ADDR = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Six 32-bit words; index 5 is word 0 (most significant).
    typedef logic [5:0][31:0] key6_t;

    state_t     state_q, state_d;
    logic [2:0] step_q;
    logic [1:0] wait_q;
    key6_t      work_q;
    logic       busy_q;
    logic       valid_q;
    logic [127:0] rk_q;

    logic       load;
    logic       capture;
    logic       zeroize_req;
    logic [7:0] rcon_byte;
    key6_t      key_in_w;
    key6_t      new_key_w;

    // Round key r occupies round_keys[r]; its word 4r is the top word.
    logic [NUM_ROUNDS:0][3:0][31:0] round_keys;

`ifdef AES192_KS_ZEROIZE_EN
    assign zeroize_req = ZEROIZE;
`else
    assign zeroize_req = 1'b0;
`endif

    assign key_in_w  = KEY_IN;
    assign new_key_w = STEP_NEW_KEY;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here is defaulted first so no path infers a latch.
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        if (zeroize_req) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (START) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // NEW_KEY is valid once the SubWord pipeline has filled.
                    if (wait_q == LAT) begin
                        capture = 1'b1;
                        if (step_q == LAST_STEP) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Step / wait counters, working register, status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_N) begin
            step_q  <= '0;
            wait_q  <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (zeroize_req) begin
            step_q  <= '0;
            wait_q  <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load) begin
            step_q  <= '0;
            wait_q  <= '0;
            work_q  <= key_in_w;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (capture) begin
            work_q <= new_key_w;
            wait_q <= '0;
            if (step_q == LAST_STEP) begin
                // Step counter parks at 7; the next load clears it.
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end else if (state_q == RUN) begin
            wait_q <= wait_q + 2'd1;
        end
    end

    // Rcon for AES-192 never reaches the 0x1b reduction, so it is a plain shift.
    always_comb begin
        rcon_byte = 8'h01 << step_q;
        STEP_RCON = '0;
        if (state_q == RUN) begin
            STEP_RCON = {rcon_byte, 24'h0};
        end
    end

    assign STEP_PREV_KEY = work_q;
    assign BUSY          = busy_q;
    assign KEYS_VALID    = valid_q;

    // -------------------------------------------------------------------------
    // Round-key storage: one register per word, write enable decoded from the
    // word's 6-word group. Group 0 is the cipher key, group g is the output of
    // step g-1. Step 7 outputs words 48..53; only 48..51 have a home here.
    // -------------------------------------------------------------------------
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        localparam int GRP = w / 6;
        localparam int OFF = w % 6;

        logic        wr_en;
        logic [31:0] wr_data;
        logic [31:0] word_q;

        if (GRP == 0) begin : g_key
            assign wr_en   = load;
            assign wr_data = key_in_w[5-OFF];
        end else begin : g_step
            assign wr_en   = capture && (step_q == 3'(GRP - 1));
            assign wr_data = new_key_w[5-OFF];
        end

        // NOTE: the key store is reset like ordinary flops so reset leaves no key material behind.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                word_q <= '0;
            end else if (zeroize_req) begin
                word_q <= '0;
            end else if (wr_en) begin
                word_q <= wr_data;
            end
        end

        assign round_keys[w/4][3-(w%4)] = word_q;
    end

    // -------------------------------------------------------------------------
    // Read port: decryption order, one-cycle latency. Reads see pre-edge
    // contents, so a word written on the same edge returns its old value.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rk_q <= '0;
        end else if (zeroize_req) begin
            rk_q <= '0;
        end else if (RK_ADDR <= LAST_ADDR) begin
            rk_q <= round_keys[LAST_ADDR - RK_ADDR];
        end else begin
            rk_q <= '0;
        end
    end

    assign RK_DATA = rk_q;

endmodule

// File: tb/tb_aes192_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes192_key_schedule_ctrl
//
// Drives aes192_key_schedule_ctrl with directed and random cipher keys. The
// external step datapath is modelled here as a SBOX_LAT-deep pipeline around
// one AES-192 expansion step. Expected round keys come from a word-by-word
// FIPS-197 key expansion of the same key.
// -----------------------------------------------------------------------------
module tb_aes192_key_schedule_ctrl;

    localparam int SBOX_LAT = 1;
    localparam int STEP_CYC = SBOX_LAT + 1;
    localparam int RUN_CYC  = 8 * STEP_CYC;

    localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    logic         CLK;
    logic         RESET_N;
    logic         START;
`ifdef AES192_KS_ZEROIZE_EN
    logic         ZEROIZE;
`endif
    logic [191:0] KEY_IN;
    logic         BUSY;
    logic         KEYS_VALID;
    logic [191:0] STEP_PREV_KEY;
    logic [31:0]  STEP_RCON;
    logic [191:0] STEP_NEW_KEY;
    logic [3:0]   RK_ADDR;
    logic [127:0] RK_DATA;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sbox_tab [256];
    logic [31:0] ref_w    [52];

    aes192_key_schedule_ctrl #(
        .SBOX_LAT   (SBOX_LAT),
        .NUM_ROUNDS (12)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .START         (START),
`ifdef AES192_KS_ZEROIZE_EN
        .ZEROIZE       (ZEROIZE),
`endif
        .KEY_IN        (KEY_IN),
        .BUSY          (BUSY),
        .KEYS_VALID    (KEYS_VALID),
        .STEP_PREV_KEY (STEP_PREV_KEY),
        .STEP_RCON     (STEP_RCON),
        .STEP_NEW_KEY  (STEP_NEW_KEY),
        .RK_ADDR       (RK_ADDR),
        .RK_DATA       (RK_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------------------------------------------------------------
    // AES helpers
    // ---------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                            ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    // One expansion step: six new words from six old words and a round constant.
    function automatic logic [191:0] step_model(input logic [191:0] prev, input logic [7:0] rc);
        logic [191:0] nxt;
        logic [31:0]  t;
        logic [31:0]  w5 = prev[31:0];
        t = sub_word({w5[23:0], w5[31:24]}) ^ {rc, 24'h0};
        for (int j = 0; j < 6; j++) begin
            t = prev[191-32*j -: 32] ^ t;
            nxt[191-32*j -: 32] = t;
        end
        return nxt;
    endfunction

    // Step datapath stand-in: result valid SBOX_LAT cycles after inputs change.
    logic [191:0] pipe_q [SBOX_LAT];
    always @(posedge CLK) begin
        pipe_q[0] <= step_model(STEP_PREV_KEY, STEP_RCON[31:24]);
        for (int i = 1; i < SBOX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign STEP_NEW_KEY = pipe_q[SBOX_LAT-1];

    // FIPS-197 key expansion, Nk = 6, 52 words.
    task automatic build_ref(input logic [191:0] key);
        for (int i = 0; i < 6; i++) ref_w[i] = key[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            logic [31:0] t = ref_w[i-1];
            if (i % 6 == 0) t = sub_word({t[23:0], t[31:24]}) ^ (32'h0100_0000 << (i/6 - 1));
            ref_w[i] = ref_w[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int addr);
        int r;
        if (addr > 12) return 128'h0;
        r = 12 - addr;
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    function automatic logic [191:0] ref_block(input int s);
        logic [191:0] v;
        for (int j = 0; j < 6; j++) v[191-32*j -: 32] = ref_w[6*s+j];
        return v;
    endfunction

    function automatic logic [191:0] rand_key();
        logic [191:0] v;
        for (int j = 0; j < 6; j++) v[32*j +: 32] = $urandom();
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Checking and stimulus tasks
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one expansion and checks the cycle-by-cycle sequencing. With
    // glitch_at >= 0 a second START carrying glitch_key is pulsed in RUN.
    task automatic run_expansion(input logic [191:0] key, input int glitch_at,
                                 input logic [191:0] glitch_key);
        build_ref(key);
        @(negedge CLK);
        START  = 1'b1;
        KEY_IN = key;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 0; k < RUN_CYC; k++) begin
            if (k > 0) @(negedge CLK);
            START = 1'b0;
            check($sformatf("busy k=%0d", k), BUSY, 1'b1);
            check($sformatf("valid_low k=%0d", k), KEYS_VALID, 1'b0);
            check($sformatf("rcon k=%0d", k), STEP_RCON, 32'h0100_0000 << (k / STEP_CYC));
            if (k % STEP_CYC == 0)
                check($sformatf("prev_key step=%0d", k / STEP_CYC), STEP_PREV_KEY,
                      ref_block(k / STEP_CYC));
            if (k == glitch_at) begin
                START  = 1'b1;
                KEY_IN = glitch_key;
            end
        end
        @(negedge CLK);
        START = 1'b0;
        check("busy_done", BUSY, 1'b0);
        check("valid_done", KEYS_VALID, 1'b1);
        check("rcon_done", STEP_RCON, 32'h0);
    endtask

    task automatic read_one(input int addr, input logic [127:0] exp, input string tag);
        @(negedge CLK);
        RK_ADDR = 4'(addr);
        @(negedge CLK);
        check(tag, RK_DATA, exp);
    endtask

    task automatic read_all(input bit expect_zero);
        for (int a = 0; a < 16; a++)
            read_one(a, expect_zero ? 128'h0 : exp_rk(a), $sformatf("rk addr=%0d", a));
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        logic [191:0] key_a;
        logic [191:0] key_b;

        RESET_N = 1'b1;
        START   = 1'b0;
        KEY_IN  = '0;
        RK_ADDR = 4'd0;
`ifdef AES192_KS_ZEROIZE_EN
        ZEROIZE = 1'b0;
`endif
        init_sbox();

        #1 RESET_N = 1'b0;
        #1;
        check("reset busy", BUSY, 1'b0);
        check("reset valid", KEYS_VALID, 1'b0);
        check("reset rk_data", RK_DATA, 128'h0);
        check("reset prev_key", STEP_PREV_KEY, 192'h0);
        check("reset rcon", STEP_RCON, 32'h0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // FIPS-197 AES-192 example key.
        run_expansion(FIPS_KEY, -1, '0);
        read_one(0,  128'he98ba06f448c773c8ecc720401002202, "fips addr0");
        read_one(11, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, "fips addr11");
        read_one(12, 128'h8e73b0f7da0e6452c810f32b809079e5, "fips addr12");
        read_one(14, 128'h0, "fips addr14");
        read_all(1'b0);

        // START during RUN must not disturb the expansion (restart from DONE).
        key_a = rand_key();
        key_b = rand_key();
        run_expansion(key_a, 5, key_b);
        read_all(1'b0);

        // Asynchronous reset in the middle of RUN.
        @(negedge CLK);
        RK_ADDR = 4'd12;
        START   = 1'b1;
        KEY_IN  = rand_key();
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("midrun reset busy", BUSY, 1'b0);
        check("midrun reset valid", KEYS_VALID, 1'b0);
        check("midrun reset rk_data", RK_DATA, 128'h0);
        check("midrun reset prev_key", STEP_PREV_KEY, 192'h0);
        check("midrun reset rcon", STEP_RCON, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        read_all(1'b1);
        run_expansion(rand_key(), -1, '0);
        read_all(1'b0);

`ifdef AES192_KS_ZEROIZE_EN
        // Zeroize in DONE wipes everything.
        @(negedge CLK);
        RK_ADDR = 4'd0;
        ZEROIZE = 1'b1;
        @(negedge CLK);
        ZEROIZE = 1'b0;
        check("zeroize valid", KEYS_VALID, 1'b0);
        check("zeroize busy", BUSY, 1'b0);
        check("zeroize rk_data", RK_DATA, 128'h0);
        check("zeroize prev_key", STEP_PREV_KEY, 192'h0);
        read_all(1'b1);

        // Zeroize wins over START on the same edge.
        run_expansion(rand_key(), -1, '0);
        @(negedge CLK);
        ZEROIZE = 1'b1;
        START   = 1'b1;
        KEY_IN  = rand_key();
        @(negedge CLK);
        ZEROIZE = 1'b0;
        START   = 1'b0;
        repeat (2) @(negedge CLK);
        check("zeroize+start busy", BUSY, 1'b0);
        check("zeroize+start valid", KEYS_VALID, 1'b0);
        check("zeroize+start rcon", STEP_RCON, 32'h0);
        check("zeroize+start prev_key", STEP_PREV_KEY, 192'h0);

        // Zeroize aborts a RUN in progress.
        @(negedge CLK);
        START  = 1'b1;
        KEY_IN = rand_key();
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        ZEROIZE = 1'b1;
        @(negedge CLK);
        ZEROIZE = 1'b0;
        check("abort busy", BUSY, 1'b0);
        repeat (RUN_CYC + 4) @(negedge CLK);
        check("abort valid", KEYS_VALID, 1'b0);
        check("abort rcon", STEP_RCON, 32'h0);
        run_expansion(rand_key(), -1, '0);
        read_all(1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
